// File: rtl/reloj_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : reloj_display_scan
// Brief    : Multiplexed 4-digit 7-segment scanner for the clock core, with
//            ghost blanking, per-digit blink, H1 leading-zero blanking and a
//            frame-start input snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module reloj_display_scan #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 1,
    parameter int BLINK_DIV = 250000,
    parameter int LZB       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] M0,
    input  logic [3:0] M1,
    input  logic [3:0] H0,
    input  logic [1:0] H1,
    input  logic       Dots,
    input  logic [3:0] blink_mask,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int c_scan_w  = $clog2(SCAN_DIV);
    localparam int c_blink_w = $clog2(BLINK_DIV);
    localparam logic [c_scan_w-1:0]  c_scan_last  = c_scan_w'(SCAN_DIV - 1);
    localparam logic [c_scan_w-1:0]  c_blank      = c_scan_w'(BLANK_CYC);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);

    logic [c_scan_w-1:0]  r_scan_cnt;
    logic [1:0]           r_idx;
    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_phase;
    logic [3:0]           r_sh_m0, r_sh_m1, r_sh_h0, r_sh_h1, r_sh_mask;
    logic                 r_sh_dots;
    logic [6:0]           r_seg;
    logic                 r_dp;
    logic [3:0]           r_an;

    logic                 w_scan_wrap;
    logic                 w_frame_start;
    logic [3:0]           w_digit;
    logic [6:0]           w_seg;
    logic                 w_suppress;
    logic [3:0]           w_an;
    logic                 w_dp;

    assign w_scan_wrap   = (r_scan_cnt == c_scan_last);
    assign w_frame_start = (r_scan_cnt == '0) && (r_idx == 2'd0);

    always_comb begin
        w_digit = r_sh_m0;
        case (r_idx)
            2'd0:    w_digit = r_sh_m0;
            2'd1:    w_digit = r_sh_m1;
            2'd2:    w_digit = r_sh_h0;
            default: w_digit = r_sh_h1;
        endcase
    end

    // Non-decimal codes show a lone dash so a corrupted digit is visible.
    always_comb begin
        w_seg = 7'h40;
        case (w_digit)
            4'd0:    w_seg = 7'h3F;
            4'd1:    w_seg = 7'h06;
            4'd2:    w_seg = 7'h5B;
            4'd3:    w_seg = 7'h4F;
            4'd4:    w_seg = 7'h66;
            4'd5:    w_seg = 7'h6D;
            4'd6:    w_seg = 7'h7D;
            4'd7:    w_seg = 7'h07;
            4'd8:    w_seg = 7'h7F;
            4'd9:    w_seg = 7'h6F;
            default: w_seg = 7'h40;
        endcase
    end

    always_comb begin
        w_suppress = (r_sh_mask[r_idx] && !r_phase) ||
                     ((LZB != 0) && (r_idx == 2'd3) && (r_sh_h1 == 4'd0));
        w_an = 4'b0000;
        if ((r_scan_cnt >= c_blank) && !w_suppress) begin
            w_an = 4'b0001 << r_idx;
        end
        w_dp = (r_idx == 2'd2) && (w_an != 4'b0000) && r_sh_dots;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_idx       <= 2'd0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
            r_sh_m0     <= 4'd0;
            r_sh_m1     <= 4'd0;
            r_sh_h0     <= 4'd0;
            r_sh_h1     <= 4'd0;
            r_sh_mask   <= 4'd0;
            r_sh_dots   <= 1'b0;
            r_seg       <= 7'd0;
            r_dp        <= 1'b0;
            r_an        <= 4'd0;
        end else begin
            r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
            if (w_scan_wrap) begin
                r_idx <= r_idx + 2'd1;
            end

            r_blink_cnt <= (r_blink_cnt == c_blink_last) ? '0 : r_blink_cnt + 1'b1;
            if (r_blink_cnt == c_blink_last) begin
                r_phase <= ~r_phase;
            end

            // Shadow is frozen for the whole frame so a digit update cannot tear.
            if (w_frame_start) begin
                r_sh_m0   <= M0;
                r_sh_m1   <= M1;
                r_sh_h0   <= H0;
                r_sh_h1   <= {2'b00, H1};
                r_sh_mask <= blink_mask;
                r_sh_dots <= Dots;
            end

            r_seg <= w_seg;
            r_dp  <= w_dp;
            r_an  <= w_an;
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp;
    assign an  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_reloj_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_reloj_display_scan
// Brief    : Directed bench for reloj_display_scan with a frame-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reloj_display_scan;

    localparam int SD = 4;
    localparam int BC = 1;
    localparam int BD = 64;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] M0 = 4'd0, M1 = 4'd0, H0 = 4'd0, blink_mask = 4'd0;
    logic [1:0] H1 = 2'd0;
    logic       Dots = 1'b0;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [3:0] an_a, an_b;

    always #5 clk = ~clk;

    reloj_display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD), .LZB(1)) dut_a (
        .clk(clk), .rst(rst), .M0(M0), .M1(M1), .H0(H0), .H1(H1), .Dots(Dots),
        .blink_mask(blink_mask), .seg(seg_a), .dp(dp_a), .an(an_a)
    );

    reloj_display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD), .LZB(0)) dut_b (
        .clk(clk), .rst(rst), .M0(M0), .M1(M1), .H0(H0), .H1(H1), .Dots(Dots),
        .blink_mask(blink_mask), .seg(seg_b), .dp(dp_b), .an(an_b)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic cmp(input string name, input logic [11:0] act, input logic [11:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F; 4'd1: return 7'h06; 4'd2: return 7'h5B;
            4'd3: return 7'h4F; 4'd4: return 7'h66; 4'd5: return 7'h6D;
            4'd6: return 7'h7D; 4'd7: return 7'h07; 4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Output after the kk-th clock since reset, as {seg, dp, an}.
    function automatic logic [11:0] model_out(input int kk, input logic [3:0] d0, d1, d2, d3,
                                              input logic dots, input logic [3:0] mask, input bit lzb);
        int scan = kk % SD;
        int idx = (kk / SD) % 4;
        bit visible_phase = ((kk / BD) % 2) == 0;
        logic [3:0] dig = (idx == 0) ? d0 : (idx == 1) ? d1 : (idx == 2) ? d2 : d3;
        bit show = (scan >= BC) && !(mask[idx] && !visible_phase) && !(lzb && idx == 3 && d3 == 4'd0);
        logic [3:0] a = show ? 4'(1 << idx) : 4'd0;
        return {dec(dig), (idx == 2 && show) ? dots : 1'b0, a};
    endfunction

    int         k = 0;
    bit         mvalid = 1'b0;
    logic [3:0] sh0 = 0, sh1 = 0, sh2 = 0, sh3 = 0, sh_mask = 0;
    logic       sh_dots = 1'b0;
    logic [11:0] exp_a = 0, exp_b = 0;

    always @(posedge clk) begin
        if (rst) begin
            k <= 0;
            mvalid <= 1'b1;
            {sh0, sh1, sh2, sh3, sh_mask, sh_dots} <= '0;
            exp_a <= 12'd0;
            exp_b <= 12'd0;
        end else begin
            exp_a <= model_out(k, sh0, sh1, sh2, sh3, sh_dots, sh_mask, 1'b1);
            exp_b <= model_out(k, sh0, sh1, sh2, sh3, sh_dots, sh_mask, 1'b0);
            if (k % FRAME == 0) begin
                sh0 <= M0; sh1 <= M1; sh2 <= H0; sh3 <= {2'b00, H1};
                sh_mask <= blink_mask; sh_dots <= Dots;
            end
            k <= k + 1;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            cmp("model_lzb1", {seg_a, dp_a, an_a}, exp_a);
            cmp("model_lzb0", {seg_b, dp_b, an_b}, exp_b);
        end
    end

    // Frame position of the output currently visible (0 = snapshot cycle).
    function automatic int cur_p();
        return (k + FRAME - 1) % FRAME;
    endfunction

    task automatic wait_p(input int target);
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (cur_p() == target) return;
        end
        cmp("wait_p_timeout", 12'd0, 12'd1);
    endtask

    logic [3:0] an_seq [16] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2,
                                 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8};
    logic [6:0] seg_slot [4] = '{7'h4F, 7'h66, 7'h5B, 7'h06};

    int cnt_hi, cnt_lo;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("reset_an", 12'(an_a), 12'h0);
        cmp("reset_seg", 12'(seg_a), 12'h0);
        cmp("reset_dp", 12'(dp_a), 12'h0);

        // Basic scan
        M0 = 4'd3; M1 = 4'd4; H0 = 4'd2; H1 = 2'd1; Dots = 1'b1; blink_mask = 4'd0;
        rst = 1'b0;
        wait_p(15);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cmp("scan_an", 12'(an_a), 12'(an_seq[i]));
            cmp("scan_seg", 12'(seg_a), 12'(seg_slot[i / 4]));
            cmp("scan_dp", 12'(dp_a), 12'(an_a == 4'h4));
        end

        // Leading zero blanking
        H1 = 2'd0; H0 = 4'd9;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i >= 12) cmp("lzb_an", 12'(an_a), 12'h0);
            if (i >= 8 && i < 12) cmp("lzb_h0_seg", 12'(seg_a), 12'h6F);
            if (i >= 13) begin
                cmp("nolzb_an", 12'(an_b), 12'h8);
                cmp("nolzb_seg", 12'(seg_b), 12'h3F);
            end
        end

        // Blink on hours digits
        H1 = 2'd1; blink_mask = 4'b1100;
        wait_p(15);
        cnt_hi = 0; cnt_lo = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (an_a == 4'h4 || an_a == 4'h8) cnt_hi++;
            if (an_a == 4'h1) cnt_lo++;
        end
        cmp("blink_hours_cnt", 12'(cnt_hi), 12'd48);
        cmp("blink_m0_cnt", 12'(cnt_lo), 12'd48);

        // Tearing protection
        blink_mask = 4'd0; M0 = 4'd5;
        wait_p(15);
        wait_p(1);
        cmp("tear_before", 12'(seg_a), 12'h6D);
        wait_p(5);
        M0 = 4'd7;
        wait_p(15);
        wait_p(1);
        cmp("tear_after", 12'(seg_a), 12'h07);

        // Invalid BCD
        M1 = 4'hC;
        wait_p(15);
        wait_p(5);
        cmp("invalid_bcd_seg", 12'(seg_a), 12'h40);

        // Mid-frame reset with idx=2, scan_cnt=2 at the reset edge
        wait_p(9);
        rst = 1'b1;
        @(negedge clk);
        cmp("midrst_an", 12'(an_a), 12'h0);
        cmp("midrst_seg", 12'(seg_a), 12'h0);
        cmp("midrst_dp", 12'(dp_a), 12'h0);
        rst = 1'b0;
        @(negedge clk);
        cmp("post_rst_blank", 12'(an_a), 12'h0);
        @(negedge clk);
        cmp("post_rst_first", 12'(an_a), 12'h1);

        repeat (2 * FRAME) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reloj_display_scan.md
Name: reloj_display_scan

Overview:
- Downstream stage of the clock core.
- Consumes the BCD time digits M0, M1, H0, H1 and the Dots flag that the core produces.
- Drives a 4-digit common-anode-select, multiplexed 7-segment display with one-hot digit enables, inter-digit ghost blanking, per-digit blink for set mode and H1 leading-zero blanking.
- A frame-start snapshot of the inputs prevents mid-frame tearing.

Parameters:
- SCAN_DIV, 1000: clocks per digit slot; legal range 2..65535.
- BLANK_CYC, 1: clocks at the start of each slot with all anodes off; legal range 1..SCAN_DIV-1.
- BLINK_DIV, 250000: clocks per blink half-period; legal range 2..2^24-1.
- LZB, 1: 1 = blank H1 when it is 0; 0 = always show H1.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- M0  input  4  minutes units, BCD.
- M1  input  4  minutes tens, BCD.
- H0  input  4  hours units, BCD.
- H1  input  2  hours tens, zero-extended to 4 bits internally.
- Dots  input  1  colon/seconds indicator.
- blink_mask  input  4  bit i = 1 makes digit i blink (0=M0, 1=M1, 2=H0, 3=H1).
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
- dp  output  1  decimal point, active-high.
- an  output  4  digit enable, one-hot or all-zero, active-high; an[i] selects digit i.

Behaviour:
- Reset (sync, rst=1 at a clock edge):
  - Internal state: scan_cnt=0, idx=0, blink_cnt=0, phase=1 (visible), shadow digits and dots = 0.
  - Outputs: seg=0, dp=0, an=0.
  - Reset asserted mid-frame aborts immediately; the scan restarts at idx 0.
- scan_cnt:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - On wrap, idx increments 0→1→2→3→0 (2-bit wrap).
- Snapshot:
  - Shadow registers load M0, M1, H0, H1, Dots and blink_mask on every edge where scan_cnt==0 and idx==0.
  - This includes the first edge after reset.
  - Input changes between snapshots have no visible effect until the next frame.
- blink_cnt:
  - Counts 0..BLINK_DIV-1 free-running, independent of the scan.
  - On wrap, phase toggles.
- Outputs are registered: values in cycle t+1 are a function of state in cycle t.
  - an = 0 while scan_cnt < BLANK_CYC (ghost blanking; this also covers the snapshot-load cycle).
  - Otherwise an = one-hot(idx), unless suppressed by either rule below, in which case an = 0:
    - shadow blink_mask[idx]=1 and phase=0;
    - LZB=1, idx=3 and shadow H1=0.
  - seg = decode(shadow digit[idx]), independent of an.
  - dp = shadow Dots when idx==2 and an is nonzero; 0 otherwise.
- Decode (hex, {g..a}):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any value 10..15 = 40 (dash only); no X propagation.
- Invariants:
  - At most one an bit is set in any cycle.
  - an is 0 for exactly BLANK_CYC cycles per slot, observed at the output one cycle delayed.
  - Frame length is 4*SCAN_DIV clocks.
- Simultaneous events:
  - blink wrap and slot change on the same edge: both take effect; the new phase applies to the new slot.
  - rst overrides all other events.

Test Plan:
1. Params SCAN_DIV=4, BLANK_CYC=1, BLINK_DIV=64, LZB=1.
   - Stimulus: rst 2 cycles; M0=3, M1=4, H0=2, H1=1, Dots=1, blink_mask=0.
   - Response: an sequence repeats 0,1,1,1,0,2,2,2,0,4,4,4,0,8,8,8 (hex).
   - seg is 4F / 66 / 5B / 06 in the respective slots; dp=1 only while an=4.
2. Leading zero: H1=0, H0=9.
   - Response: an stays 0 through the whole idx=3 slot; idx=2 shows seg=6F.
   - Repeat with LZB=0: an=8 with seg=3F.
3. Blink: blink_mask=4'b1100.
   - Response: an=4 and an=8 are absent for 64 consecutive clocks, then present for 64.
   - an=1 and an=2 are present in every frame.
4. Tearing: change M0 from 5 to 7 while idx=1.
   - Response: the remainder of the frame is unchanged.
   - The M0 slot shows 6D in the current frame and 07 from the next frame onward.
5. Invalid BCD: M1=4'hC.
   - Response: seg=40 in the idx=1 slot.
   - No X appears on seg, dp or an.
6. Mid-frame reset: assert rst while idx=2, scan_cnt=2.
   - Response: on the next clock an=0, seg=0, dp=0.
   - After release, the first nonzero an is 1, appearing exactly BLANK_CYC+1 clocks later.
